// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operator codes, keypad geometry
// and the scanner FSM state type.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 5;
  localparam int COL_OPS  = 4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

  // Lowest-indexed active-low row wins when several rows are pressed together.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    // NOTE: assign a default before the loop so the result is driven on every path.
    lowest_low_row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) lowest_low_row = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    // NOTE: non-blocking so each stage takes the other's pre-edge value; blocking would merge the two flops.
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x5 matrix keypad scanner: column drive, debounce, key encoding, one-cycle event pulses.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [4:0] col_n,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic [1:0] opcode,
  output logic       eq,
  output logic       key_held
);

  localparam int CNT_W = $clog2(SCAN_DIV > DEBOUNCE_CYCLES ? SCAN_DIV : DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       OPS_IDX   = 3'(COL_OPS);

  state_t           state;
  logic [3:0]       rows_s;
  logic [2:0]       col_idx;
  logic [CNT_W-1:0] scan_cnt;
  logic [CNT_W-1:0] deb_cnt;
  logic [3:0]       key_pat;
  logic [1:0]       key_row;

  function automatic logic [2:0] next_col(input logic [2:0] idx);
    return (idx == OPS_IDX) ? 3'd0 : idx + 3'd1;
  endfunction

  // Idle rows read high, so the synchronizer resets to "no key".
  sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
    .clock (clock),
    .reset (reset),
    .d     (row_n),
    .q     (rows_s)
  );

  assign col_n = ~(5'b00001 << col_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= SCAN;
      col_idx  <= 3'd0;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      key_pat  <= 4'hF;
      key_row  <= 2'd0;
      newhex   <= 1'b0;
      newop    <= 1'b0;
      eq       <= 1'b0;
      hexcode  <= 4'h0;
      opcode   <= OP_ADD;
      key_held <= 1'b0;
    end else begin
      newhex <= 1'b0;
      newop  <= 1'b0;
      eq     <= 1'b0;

      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (rows_s != 4'hF) begin
              key_pat <= rows_s;
              key_row <= lowest_low_row(rows_s);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= next_col(col_idx);
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (rows_s != key_pat) begin
            scan_cnt <= '0;
            state    <= SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            // Pulses are registered here so they are high exactly during EMIT.
            if (col_idx != OPS_IDX) begin
              newhex  <= 1'b1;
              hexcode <= {key_row, col_idx[1:0]};
            end else begin
              case (key_row)
                2'd0:    begin newop <= 1'b1; opcode <= OP_ADD; end
                2'd1:    begin newop <= 1'b1; opcode <= OP_SUB; end
                2'd2:    begin newop <= 1'b1; opcode <= OP_MUL; end
                default: eq <= 1'b1;
              endcase
            end
            key_held <= 1'b1;
            state    <= EMIT;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        EMIT: begin
          deb_cnt <= '0;
          state   <= RELEASE;
        end

        RELEASE: begin
          if (rows_s != 4'hF) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt  <= '0;
            scan_cnt <= '0;
            col_idx  <= next_col(col_idx);
            key_held <= 1'b0;
            state    <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad matrix model drives row_n from col_n; a queue of expected key events is checked.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [4:0] col_n;
  logic       newhex, newop, eq, key_held;
  logic [3:0] hexcode;
  logic [1:0] opcode;

  logic press [4][5];

  typedef struct {
    int kind;  // 0 hex, 1 operator, 2 equals, 3 none
    int val;
  } evt_t;

  evt_t exp_q[$];
  int   last_hex = 0;
  int   last_op  = 0;
  int   evt_seen = 0;
  int   evt_expected = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock    (clock),
    .reset    (reset),
    .row_n    (row_n),
    .col_n    (col_n),
    .newhex   (newhex),
    .hexcode  (hexcode),
    .newop    (newop),
    .opcode   (opcode),
    .eq       (eq),
    .key_held (key_held)
  );

  always #5 clock = ~clock;

  // Matrix model: a row reads low when a pressed key sits in a driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (press[r][c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic evt_t key_event(input int r, input int c);
    evt_t e;
    if (c < 4) begin
      e.kind = 0; e.val = r * 4 + c;
    end else if (r < 3) begin
      e.kind = 1; e.val = r;
    end else begin
      e.kind = 2; e.val = 0;
    end
    return e;
  endfunction

  task automatic expect_key(input int r, input int c);
    exp_q.push_back(key_event(r, c));
    evt_expected++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_col(input logic [4:0] target);
    int t = 0;
    while (col_n !== target && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("wait_col", int'(col_n), int'(target));
  endtask

  task automatic tap(input int r, input int c, input int hold, input int gap);
    expect_key(r, c);
    press[r][c] = 1'b1;
    cycles(hold);
    press[r][c] = 1'b0;
    cycles(gap);
    check("drained", exp_q.size(), 0);
    check("key_held_idle", int'(key_held), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_col_n", int'(col_n), 5'b11110);
    check("rst_newhex", int'(newhex), 0);
    check("rst_newop", int'(newop), 0);
    check("rst_eq", int'(eq), 0);
    check("rst_hexcode", int'(hexcode), 0);
    check("rst_opcode", int'(opcode), 0);
    check("rst_key_held", int'(key_held), 0);
  endtask

  // Event monitor: every pulse is matched against the head of the expected-event queue.
  int   mon_n;
  int   mon_kind;
  evt_t mon_e;
  always @(negedge clock) begin
    if (!reset && (newhex || newop || eq)) begin
      mon_n = int'(newhex) + int'(newop) + int'(eq);
      check("pulse_onehot", mon_n, 1);
      mon_kind = newhex ? 0 : (newop ? 1 : 2);
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      else begin
        mon_e.kind = 3; mon_e.val = 0;
      end
      evt_seen++;
      check("evt_kind", mon_kind, mon_e.kind);
      if (mon_e.kind == 0) last_hex = mon_e.val;
      if (mon_e.kind == 1) last_op = mon_e.val;
      check("hexcode", int'(hexcode), last_hex);
      check("opcode", int'(opcode), last_op);
      check("key_held_at_evt", int'(key_held), 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (press[r, c]) press[r][c] = 1'b0;

    reset = 1'b1;
    cycles(3);
    check_reset_outputs();
    reset = 1'b0;
    cycles(5);

    // Hex key 6, held well past release.
    tap(1, 2, 100, 40);
    // Multiply key; hexcode must keep 6.
    tap(2, 4, 60, 40);

    // Bouncing equals key: no event until it settles, then exactly one.
    press[3][4] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycles(3);
      press[3][4] = ~press[3][4];
    end
    expect_key(3, 4);
    cycles(60);
    press[3][4] = 1'b0;
    cycles(40);
    check("bounce_drained", exp_q.size(), 0);

    // Two rows in one column: row 0 wins, remaining row must not retrigger.
    expect_key(0, 1);
    press[0][1] = 1'b1;
    press[2][1] = 1'b1;
    cycles(60);
    press[0][1] = 1'b0;
    cycles(60);
    check("held_r2_only", int'(key_held), 1);
    press[2][1] = 1'b0;
    cycles(40);
    check("multi_drained", exp_q.size(), 0);
    check("multi_released", int'(key_held), 0);

    // Reset during debounce of r3c3, key still held afterwards.
    wait_col(5'b01111);
    press[3][3] = 1'b1;
    wait_col(5'b10111);
    cycles(6);
    reset = 1'b1;
    cycles(3);
    exp_q.delete();
    last_hex = 0;
    last_op  = 0;
    check_reset_outputs();
    reset = 1'b0;
    expect_key(3, 3);
    cycles(60);
    press[3][3] = 1'b0;
    cycles(40);
    check("reset_drained", exp_q.size(), 0);

    // Idle column rotation, four cycles per column with wrap.
    wait_col(5'b01111);
    wait_col(5'b11110);
    for (int i = 0; i < 40; i++) begin
      logic [4:0] exp_col;
      exp_col = ~(5'b00001 << ((i / SCAN_DIV) % 5));
      check("idle_col_n", int'(col_n), int'(exp_col));
      cycles(1);
    end
    cycles(160);

    // Random single-key presses.
    for (int k = 0; k < 12; k++) begin
      int r, c;
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(4, 0));
      tap(r, c, int'($urandom_range(80, 40)), int'($urandom_range(60, 30)));
    end

    check("evt_count", evt_seen, evt_expected);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
